// File: rtl/maxnet_pkg.sv
// Shared types and constants for the four-node Maxnet engine.
// Node count, default activation width, FSM state encoding, iteration counter width.
package maxnet_pkg;

    localparam int N_NODES    = 4;
    localparam int DEF_DATA_W = 32;
    localparam int ITER_W     = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/maxnet_winner_detect.sv
// Combinational winner detection over the four node registers.
// In: n[0..3]. Out: done (<=1 nonzero), winner index, winner_valid, argmax (lowest index on ties).
module maxnet_winner_detect
    import maxnet_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] n [N_NODES],
    output logic              done,
    output logic [1:0]        winner,
    output logic              winner_valid,
    output logic [1:0]        argmax
);

    logic [N_NODES-1:0] mask;

    always_comb begin
        for (int i = 0; i < N_NODES; i++) begin
            mask[i] = |n[i];
        end
    end

    always_comb begin
        done         = 1'b0;
        winner       = 2'd0;
        winner_valid = 1'b0;
        case (mask)
            4'b0000: done = 1'b1;
            4'b0001: begin done = 1'b1; winner = 2'd0; winner_valid = 1'b1; end
            4'b0010: begin done = 1'b1; winner = 2'd1; winner_valid = 1'b1; end
            4'b0100: begin done = 1'b1; winner = 2'd2; winner_valid = 1'b1; end
            4'b1000: begin done = 1'b1; winner = 2'd3; winner_valid = 1'b1; end
            default: done = 1'b0;
        endcase
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        argmax = 2'd0;
        for (int i = 1; i < N_NODES; i++) begin
            if ($signed(n[i]) > $signed(n[argmax])) begin
                argmax = 2'(i);
            end
        end
    end

endmodule

// File: rtl/maxnet_iter_engine.sv
// Iterative Maxnet winner-take-all core: one lateral-inhibition step per clock.
// Ports: clk, rst (async active-low), start/ready, x0..x3 in; out_valid/out_ready,
// winner, winner_valid, win_value, iter_count, timeout out.
// Optional iteration cap compiled in with MAXNET_ITER_LIMIT_EN.
module maxnet_iter_engine
    import maxnet_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int EPS_SHIFT = 3,
    parameter int MAX_ITER  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    output logic              ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        winner,
    output logic              winner_valid,
    output logic [DATA_W-1:0] win_value,
    output logic [ITER_W-1:0] iter_count,
    output logic              timeout
);

    localparam int SW = DATA_W + 2;

    state_t state, state_nx;

    logic [DATA_W-1:0] n    [N_NODES];
    logic [DATA_W-1:0] n_nx [N_NODES];
    logic [DATA_W-1:0] xin  [N_NODES];

    logic signed [SW-1:0] s_i    [N_NODES];
    logic signed [SW-1:0] d_i    [N_NODES];
    logic signed [SW-1:0] diff_i [N_NODES];

    logic       det_done;
    logic [1:0] det_winner;
    logic       det_valid;
    logic [1:0] det_argmax;

    logic cap_hit;
    logic accept;
    logic step;
    logic finish;

    maxnet_winner_detect #(
        .DATA_W (DATA_W)
    ) u_detect (
        .n            (n),
        .done         (det_done),
        .winner       (det_winner),
        .winner_valid (det_valid),
        .argmax       (det_argmax)
    );

`ifdef MAXNET_ITER_LIMIT_EN
    logic timeout_q;
    assign cap_hit = (iter_count == ITER_W'(MAX_ITER));
    assign timeout = timeout_q;
`else
    logic unused_cap;
    assign cap_hit    = 1'b0;
    assign timeout    = 1'b0;
    assign unused_cap = ^{ITER_W'(MAX_ITER), det_argmax};
`endif

    always_comb begin
        xin[0] = x0;
        xin[1] = x1;
        xin[2] = x2;
        xin[3] = x3;
    end

    // Nodes are never negative, so zero-extension is a valid widening.
    always_comb begin
        for (int i = 0; i < N_NODES; i++) begin
            s_i[i] = '0;
            for (int j = 0; j < N_NODES; j++) begin
                if (j != i) begin
                    s_i[i] = s_i[i] + $signed({2'b00, n[j]});
                end
            end
            d_i[i]    = s_i[i] >>> EPS_SHIFT;
            diff_i[i] = $signed({2'b00, n[i]}) - d_i[i];
            n_nx[i]   = diff_i[i][SW-1] ? '0 : diff_i[i][DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start)               state_nx = S_RUN;
            S_RUN:  if (det_done || cap_hit) state_nx = S_DONE;
            S_DONE: if (out_ready)           state_nx = S_IDLE;
            default:                         state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == S_IDLE);
        out_valid = (state == S_DONE);
        accept    = ready && start;
        step      = (state == S_RUN) && !det_done && !cap_hit;
        finish    = (state == S_RUN) && (det_done || cap_hit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_NODES; i++) begin
                n[i] <= '0;
            end
            iter_count <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_NODES; i++) begin
                n[i] <= xin[i][DATA_W-1] ? '0 : xin[i];
            end
            iter_count <= '0;
        end else if (step) begin
            for (int i = 0; i < N_NODES; i++) begin
                n[i] <= n_nx[i];
            end
            if (iter_count != '1) begin
                iter_count <= iter_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winner       <= 2'd0;
            winner_valid <= 1'b0;
            win_value    <= '0;
`ifdef MAXNET_ITER_LIMIT_EN
            timeout_q    <= 1'b0;
`endif
        end else if (finish) begin
            if (det_done) begin
                winner       <= det_winner;
                winner_valid <= det_valid;
                win_value    <= det_valid ? n[det_winner] : '0;
`ifdef MAXNET_ITER_LIMIT_EN
                timeout_q    <= 1'b0;
            end else begin
                winner       <= det_argmax;
                winner_valid <= 1'b0;
                win_value    <= n[det_argmax];
                timeout_q    <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_maxnet_iter_engine.sv
// Testbench for maxnet_iter_engine: directed and random jobs checked
// against an arithmetic Maxnet model; covers hold, reset abort and the optional cap.
module tb_maxnet_iter_engine;

    localparam int DW   = 32;
    localparam int EPS  = 3;
    localparam int MAXI = 20;
`ifdef MAXNET_ITER_LIMIT_EN
    localparam int CAP = MAXI;
`else
    localparam int CAP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic          ready, out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    winner;
    logic          winner_valid;
    logic [DW-1:0] win_value;
    logic [15:0]   iter_count;
    logic          timeout;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    maxnet_iter_engine #(
        .DATA_W    (DW),
        .EPS_SHIFT (EPS),
        .MAX_ITER  (MAXI)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .x0           (x0),
        .x1           (x1),
        .x2           (x2),
        .x3           (x3),
        .ready        (ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .winner       (winner),
        .winner_valid (winner_valid),
        .win_value    (win_value),
        .iter_count   (iter_count),
        .timeout      (timeout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: iterate the Maxnet equations on plain integers.
    function automatic void ref_run(input logic [DW-1:0] xi [4], input int cap,
                                    output int k, output int w, output bit wv,
                                    output longint val, output bit to, output bit conv);
        longint v [4];
        longint nv [4];
        longint tot;
        int nz;
        int best;
        for (int i = 0; i < 4; i++) begin
            v[i] = longint'($signed(xi[i]));
            if (v[i] < 0) v[i] = 0;
        end
        k = 0; w = 0; wv = 0; val = 0; to = 0; conv = 0;
        for (int it = 0; it <= 3000; it++) begin
            nz = 0;
            for (int i = 0; i < 4; i++) if (v[i] != 0) nz++;
            if (nz <= 1) begin
                conv = 1;
                for (int i = 0; i < 4; i++) begin
                    if (v[i] != 0) begin w = i; wv = 1; val = v[i]; end
                end
                return;
            end
            if (cap != 0 && k == cap) begin
                conv = 1; to = 1; best = 0;
                for (int i = 1; i < 4; i++) if (v[i] > v[best]) best = i;
                w = best; val = v[best];
                return;
            end
            tot = v[0] + v[1] + v[2] + v[3];
            for (int i = 0; i < 4; i++) begin
                nv[i] = v[i] - (tot - v[i]) / (longint'(1) << EPS);
                if (nv[i] < 0) nv[i] = 0;
            end
            v = nv;
            k++;
        end
    endfunction

    // Starts a job, measures latency to out_valid and checks the result.
    task automatic run_job(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [DW-1:0] d,
                           input bit consume);
        logic [DW-1:0] xi [4];
        int k, w, lat;
        bit wv, to, conv;
        longint val;
        xi[0] = a; xi[1] = b; xi[2] = c; xi[3] = d;
        ref_run(xi, CAP, k, w, wv, val, to, conv);
        @(negedge clk);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        start = 1'b1;
        x0 = a; x1 = b; x2 = c; x3 = d;
        @(posedge clk);
        lat = 0;
        while (1) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (out_valid) break;
            if (lat > k + 10) break;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(k + 2));
        chk({tag, "_winner"}, 64'(winner), 64'(w));
        chk({tag, "_wvalid"}, 64'(winner_valid), 64'(wv));
        chk({tag, "_value"}, 64'(win_value), 64'(val));
        chk({tag, "_iters"}, 64'(iter_count), 64'(k));
        chk({tag, "_timeout"}, 64'(timeout), 64'(to));
        if (consume) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, "_ready_after"}, 64'(ready), 64'd1);
            chk({tag, "_ovalid_after"}, 64'(out_valid), 64'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        chk({tag, "_ovalid"}, 64'(out_valid), 64'd0);
        chk({tag, "_winner"}, 64'(winner), 64'd0);
        chk({tag, "_wvalid"}, 64'(winner_valid), 64'd0);
        chk({tag, "_value"}, 64'(win_value), 64'd0);
        chk({tag, "_iters"}, 64'(iter_count), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] r [4];
        int k, w;
        bit wv, to, conv;
        longint val;
        int done_rand;
        logic [1:0] h_w;
        logic [DW-1:0] h_v;
        logic [15:0] h_i;

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;

        run_job("spec_a", 32'd100, 32'd50, 32'd20, 32'd10, 1'b1);
        chk("spec_a_value_const", 64'(win_value), 64'd83);
        run_job("spec_b", 32'd0, 32'd0, 32'd7, 32'd0, 1'b1);
        run_job("zero", 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        run_job("clamp", -32'sd5, 32'd30, 32'd0, 32'd0, 1'b1);
        run_job("neg_all", -32'sd9, -32'sd1, -32'sd100, -32'sd3, 1'b1);

`ifdef MAXNET_ITER_LIMIT_EN
        run_job("cap", 32'd40, 32'd40, 32'd0, 32'd0, 1'b1);
        chk("cap_timeout_const", 64'(timeout), 64'd1);
        chk("cap_iters_const", 64'(iter_count), 64'd20);
`endif

        // Back-to-back jobs go through run_job's one-idle-cycle handoff.
        done_rand = 0;
        for (int t = 0; t < 400 && done_rand < 25; t++) begin
            for (int i = 0; i < 4; i++) begin
                r[i] = 32'($urandom_range(0, 5000));
                if ($urandom_range(0, 9) == 0) r[i] = -r[i];
                if ($urandom_range(0, 5) == 0) r[i] = '0;
            end
            ref_run(r, CAP, k, w, wv, val, to, conv);
            if (conv && k < 200) begin
                run_job("rand", r[0], r[1], r[2], r[3], 1'b1);
                done_rand++;
            end
        end

        // Hold result with out_ready low while start pulses.
        run_job("hold", 32'd100, 32'd50, 32'd20, 32'd10, 1'b0);
        h_w = winner; h_v = win_value; h_i = iter_count;
        for (int c = 0; c < 10; c++) begin
            start = 1'b1;
            x0 = 32'd1; x1 = 32'd900; x2 = 32'd3; x3 = 32'd4;
            @(negedge clk);
            chk("hold_ovalid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(ready), 64'd0);
            chk("hold_winner", 64'(winner), 64'd0);
            chk("hold_value", 64'(win_value), 64'd83);
            chk("hold_iters", 64'(iter_count), 64'd5);
            chk("hold_stable", 64'({h_w, h_v, h_i}), 64'({winner, win_value, iter_count}));
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_release_ready", 64'(ready), 64'd1);

        // Tie never converges; abort it with reset mid-RUN.
        start = 1'b1;
        x0 = 32'd40; x1 = 32'd40; x2 = 32'd0; x3 = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_inrun_ready", 64'(ready), 64'd0);
        #2 rst = 1'b0;
        #1 chk_reset_vals("abort");
        @(negedge clk);
        rst = 1'b1;
        run_job("post_reset", 32'd0, 32'd0, 32'd0, 32'd12, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
